// File: rtl/key_scanner_pkg.sv
// key_scanner_pkg: shared types and constants for the key scanner.
//   - scan_state_e : note gate FSM states (IDLE, PLAY, TAIL)
//   - NUM_NOTES    : number of note keys (bits 0..6 of the button bus)
//   - SUSTAIN_BIT  : position of the sustain pedal key on the button bus
//   - lowest_note  : priority encoder returning the lowest pressed note index
package key_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    TAIL = 2'd2
  } scan_state_e;

  localparam int NUM_NOTES   = 7;
  localparam int SUSTAIN_BIT = 7;

  // Lowest set index wins; scanning downwards lets the lowest bit overwrite.
  function automatic logic [2:0] lowest_note(input logic [NUM_NOTES-1:0] notes);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (notes[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one push-button channel.
//   Two-flop synchronizer on the raw active-low button, inversion to
//   active-high, then a stability counter that flips the debounced level
//   once the synchronized level has disagreed with it for DEBOUNCE_CYCLES
//   consecutive cycles.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   btn_n  - raw asynchronous button, active-low
//   key_db - debounced key state, active-high (registered)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic key_db
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             key_db_r;

  logic             pressed_s;
  logic             differ_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             key_next_s;

  assign pressed_s = ~sync2_r;
  assign differ_s  = pressed_s ^ key_db_r;
  assign key_db    = key_db_r;

  // Debounce counter and toggle decision; any agreeing cycle restarts the count.
  always_comb begin
    cnt_next_s = cnt_r;
    key_next_s = key_db_r;
    if (differ_s) begin
      if (cnt_r == CNT_LAST) begin
        key_next_s = ~key_db_r;
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        key_next_s = key_db_r;
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // Synchronizer, counter and debounced level registers (reset = released).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      cnt_r    <= {CNT_W{1'b0}};
      key_db_r <= 1'b0;
    end else begin
      sync1_r  <= btn_n;
      sync2_r  <= sync1_r;
      cnt_r    <= cnt_next_s;
      key_db_r <= key_next_s;
    end
  end

endmodule

// File: rtl/key_scanner.sv
// key_scanner: debounced 7-note keyboard with sustain pedal driving a
// note gate for a downstream tone generator.
//   Eight key_debounce channels clean up the raw buttons; the lowest held
//   note is selected; a three-state FSM (IDLE/PLAY/TAIL) produces a
//   registered gate with a release tail that the sustain key can hold open.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   btn[7:0]    - raw buttons, active-low; 0..6 notes, 7 sustain
//   keys_db     - debounced key state, active-high
//   note_idx    - current note index 0..6
//   note_on     - gate, high while the note sounds
//   note_strobe - one-cycle pulse on gate rise or note index change
module key_scanner
  import key_scanner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RELEASE_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  output logic [7:0] keys_db,
  output logic [2:0] note_idx,
  output logic       note_on,
  output logic       note_strobe
);

  localparam int TAIL_W = ($clog2(RELEASE_CYCLES) < 1) ? 1 : $clog2(RELEASE_CYCLES);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(RELEASE_CYCLES - 1);

  logic [7:0]           keys_db_s;
  logic [NUM_NOTES-1:0] notes_s;
  logic                 any_note_s;
  logic                 sustain_s;
  logic [2:0]           sel_idx_s;

  scan_state_e          state_r;
  scan_state_e          state_s;
  logic [2:0]           note_idx_r;
  logic [2:0]           note_idx_s;
  logic                 note_on_r;
  logic                 note_on_s;
  logic                 note_strobe_r;
  logic                 note_strobe_s;
  logic [TAIL_W-1:0]    tail_cnt_r;
  logic [TAIL_W-1:0]    tail_cnt_s;

  for (genvar g = 0; g < 8; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn[g]),
      .key_db (keys_db_s[g])
    );
  end

  assign notes_s    = keys_db_s[NUM_NOTES-1:0];
  assign any_note_s = |notes_s;
  assign sustain_s  = keys_db_s[SUSTAIN_BIT];
  assign sel_idx_s  = lowest_note(notes_s);

  assign keys_db     = keys_db_s;
  assign note_idx    = note_idx_r;
  assign note_on     = note_on_r;
  assign note_strobe = note_strobe_r;

  // Gate FSM: next state and next values of every registered output.
  always_comb begin
    state_s       = state_r;
    note_idx_s    = note_idx_r;
    note_on_s     = note_on_r;
    note_strobe_s = 1'b0;
    tail_cnt_s    = tail_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_note_s) begin
          state_s       = PLAY;
          note_idx_s    = sel_idx_s;
          note_on_s     = 1'b1;
          note_strobe_s = 1'b1;
        end else begin
          note_on_s = 1'b0;
        end
      end
      PLAY: begin
        note_on_s = 1'b1;
        if (any_note_s) begin
          note_idx_s    = sel_idx_s;
          note_strobe_s = (sel_idx_s != note_idx_r);
        end else begin
          state_s    = TAIL;
          tail_cnt_s = {TAIL_W{1'b0}};
        end
      end
      TAIL: begin
        // A new press outranks tail expiry, so the gate never drops on a retrigger.
        if (any_note_s) begin
          state_s       = PLAY;
          note_idx_s    = sel_idx_s;
          note_on_s     = 1'b1;
          note_strobe_s = 1'b1;
        end else if (tail_cnt_r == TAIL_LAST) begin
          state_s    = IDLE;
          note_on_s  = 1'b0;
          tail_cnt_s = {TAIL_W{1'b0}};
        end else if (sustain_s) begin
          note_on_s  = 1'b1;
          tail_cnt_s = {TAIL_W{1'b0}};
        end else begin
          note_on_s  = 1'b1;
          tail_cnt_s = tail_cnt_r + TAIL_W'(1);
        end
      end
      default: begin
        state_s    = IDLE;
        note_idx_s = 3'd0;
        note_on_s  = 1'b0;
        tail_cnt_s = {TAIL_W{1'b0}};
      end
    endcase
  end

  // FSM state, tail counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      note_idx_r    <= 3'd0;
      note_on_r     <= 1'b0;
      note_strobe_r <= 1'b0;
      tail_cnt_r    <= {TAIL_W{1'b0}};
    end else begin
      state_r       <= state_s;
      note_idx_r    <= note_idx_s;
      note_on_r     <= note_on_s;
      note_strobe_r <= note_strobe_s;
      tail_cnt_r    <= tail_cnt_s;
    end
  end

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: directed self-checking bench for key_scanner with
// DEBOUNCE_CYCLES=4 and RELEASE_CYCLES=8. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point.
module tb_key_scanner;

  logic       clk;
  logic       rst;
  logic [7:0] btn;
  logic [7:0] keys_db;
  logic [2:0] note_idx;
  logic       note_on;
  logic       note_strobe;

  int n_checks;
  int n_fail;

  key_scanner #(
    .DEBOUNCE_CYCLES(4),
    .RELEASE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .keys_db     (keys_db),
    .note_idx    (note_idx),
    .note_on     (note_on),
    .note_strobe (note_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    btn      = 8'hFF;

    // Reset
    tick(2);
    chk("rst_keys_db", keys_db, 8'h00);
    chk("rst_note_idx", {5'd0, note_idx}, 8'h00);
    chk("rst_note_on", {7'd0, note_on}, 8'h00);
    chk("rst_strobe", {7'd0, note_strobe}, 8'h00);
    rst = 1'b0;
    tick(1);
    chk("idle_note_on", {7'd0, note_on}, 8'h00);

    // Single press of key 0: keys_db after 6 edges, gate one edge later
    btn = 8'hFE;
    tick(5);
    chk("press0_not_yet", keys_db, 8'h00);
    tick(1);
    chk("press0_keys_db", keys_db, 8'h01);
    chk("press0_gate_not_yet", {7'd0, note_on}, 8'h00);
    tick(1);
    chk("press0_note_on", {7'd0, note_on}, 8'h01);
    chk("press0_note_idx", {5'd0, note_idx}, 8'h00);
    chk("press0_strobe", {7'd0, note_strobe}, 8'h01);
    tick(1);
    chk("press0_strobe_once", {7'd0, note_strobe}, 8'h00);
    chk("press0_note_on_hold", {7'd0, note_on}, 8'h01);

    // Release: tail of 8 cycles after keys_db clears
    btn = 8'hFF;
    tick(5);
    chk("rel0_keys_db_held", keys_db, 8'h01);
    tick(1);
    chk("rel0_keys_db_clear", keys_db, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("tail_note_on", {7'd0, note_on}, 8'h01);
    end
    tick(1);
    chk("tail_expired", {7'd0, note_on}, 8'h00);
    chk("tail_idx_kept", {5'd0, note_idx}, 8'h00);

    // Glitch on key 2 for 3 cycles: no change, no strobe
    btn = 8'hFB;
    tick(3);
    btn = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_keys_db", keys_db, 8'h00);
      chk("glitch_strobe", {7'd0, note_strobe}, 8'h00);
    end

    // Chord keys 3 and 5 -> lowest index 3
    btn = 8'hD7;
    tick(6);
    chk("chord_keys_db", keys_db, 8'h28);
    tick(1);
    chk("chord_idx", {5'd0, note_idx}, 8'h03);
    chk("chord_strobe", {7'd0, note_strobe}, 8'h01);
    chk("chord_note_on", {7'd0, note_on}, 8'h01);
    tick(1);
    chk("chord_strobe_once", {7'd0, note_strobe}, 8'h00);

    // Release key 3 -> index 5
    btn = 8'hDF;
    tick(6);
    chk("rel3_keys_db", keys_db, 8'h20);
    tick(1);
    chk("rel3_idx", {5'd0, note_idx}, 8'h05);
    chk("rel3_strobe", {7'd0, note_strobe}, 8'h01);
    tick(1);
    chk("rel3_strobe_once", {7'd0, note_strobe}, 8'h00);
    chk("rel3_idx_hold", {5'd0, note_idx}, 8'h05);

    // Press key 1 -> index 1
    btn = 8'hDD;
    tick(6);
    chk("press1_keys_db", keys_db, 8'h22);
    tick(1);
    chk("press1_idx", {5'd0, note_idx}, 8'h01);
    chk("press1_strobe", {7'd0, note_strobe}, 8'h01);
    tick(1);
    chk("press1_strobe_once", {7'd0, note_strobe}, 8'h00);

    // Release notes while pressing sustain: gate held indefinitely
    btn = 8'h7F;
    tick(6);
    chk("sus_keys_db", keys_db, 8'h80);
    tick(1);
    chk("sus_strobe", {7'd0, note_strobe}, 8'h00);
    for (int i = 0; i < 110; i++) begin
      tick(1);
      chk("sus_note_on", {7'd0, note_on}, 8'h01);
    end
    chk("sus_idx_held", {5'd0, note_idx}, 8'h01);

    // Release sustain: gate drops 8 edges after keys_db[7] clears
    btn = 8'hFF;
    tick(6);
    chk("sus_rel_keys_db", keys_db, 8'h00);
    tick(7);
    chk("sus_rel_last_on", {7'd0, note_on}, 8'h01);
    tick(1);
    chk("sus_rel_off", {7'd0, note_on}, 8'h00);

    // Press key 2 from IDLE, release, then re-press key 6 so it lands on tail expiry
    btn = 8'hFB;
    tick(7);
    chk("press2_idx", {5'd0, note_idx}, 8'h02);
    chk("press2_strobe", {7'd0, note_strobe}, 8'h01);
    btn = 8'hFF;
    tick(6);
    chk("rel2_keys_db", keys_db, 8'h00);
    tick(2);
    btn = 8'hBF;
    tick(6);
    chk("retrig_keys_db", keys_db, 8'h40);
    chk("retrig_tail_on", {7'd0, note_on}, 8'h01);
    tick(1);
    chk("retrig_note_on", {7'd0, note_on}, 8'h01);
    chk("retrig_idx", {5'd0, note_idx}, 8'h06);
    chk("retrig_strobe", {7'd0, note_strobe}, 8'h01);
    tick(1);
    chk("retrig_strobe_once", {7'd0, note_strobe}, 8'h00);

    // Switch to key 4, then reset mid-play
    btn = 8'hEF;
    tick(6);
    chk("key4_keys_db", keys_db, 8'h10);
    tick(1);
    chk("key4_idx", {5'd0, note_idx}, 8'h04);
    chk("key4_strobe", {7'd0, note_strobe}, 8'h01);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("midrst_note_on", {7'd0, note_on}, 8'h00);
    chk("midrst_keys_db", keys_db, 8'h00);
    chk("midrst_idx", {5'd0, note_idx}, 8'h00);
    chk("midrst_strobe", {7'd0, note_strobe}, 8'h00);
    rst = 1'b0;
    tick(5);
    chk("postrst_keys_db_wait", keys_db, 8'h00);
    tick(1);
    chk("postrst_keys_db", keys_db, 8'h10);
    chk("postrst_gate_wait", {7'd0, note_on}, 8'h00);
    tick(1);
    chk("postrst_note_on", {7'd0, note_on}, 8'h01);
    chk("postrst_idx", {5'd0, note_idx}, 8'h04);
    chk("postrst_strobe", {7'd0, note_strobe}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
